// File: rtl/key_event_arb.sv
// key_event_arb: multi-key event arbiter.
// Latches single-cycle key_flag pulses into per-key pending bits. Each cycle
// it grants at most one pending key in round-robin order and pushes the key ID
// into a small FIFO. A consumer drains the FIFO with a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   key_flag   per-key single-cycle press pulses
//   evt_valid  FIFO head holds an event
//   evt_id     key index of the head event (0 when empty)
//   evt_ready  consumer accepts the head event this cycle
//   pend       per-key pending (latched, not yet queued) bits
//   ovf        sticky flag: at least one press was lost
//   ovf_clr    single-cycle clear of ovf
module key_event_arb #(
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_flag,
  output logic               evt_valid,
  output logic [ID_W-1:0]    evt_id,
  input  logic               evt_ready,
  output logic [KEY_NUM-1:0] pend,
  output logic               ovf,
  input  logic               ovf_clr
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [KEY_NUM-1:0] pend_q, pend_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ID_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ID_W-1:0]    mem_d [FIFO_DEPTH];

  logic               fifo_full_c;
  logic               fifo_empty_c;
  logic               gnt_vld_c;
  logic [ID_W-1:0]    gnt_id_c;
  logic [KEY_NUM-1:0] gnt_oh_c;
  logic               pop_c;
  logic               loss_c;

  assign fifo_full_c  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty_c = (cnt_q == '0);

  // Round-robin search starting at rr; full test uses the current count only.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_vld_c = 1'b0;
    gnt_id_c  = '0;
    cand      = '0;
    if ((|pend_q) && !fifo_full_c) begin
      for (int unsigned i = 0; i < KEY_NUM; i++) begin
        cand = ID_W'((32'(rr_q) + i) % KEY_NUM);
        if (!gnt_vld_c && pend_q[cand]) begin
          gnt_vld_c = 1'b1;
          gnt_id_c  = cand;
        end
      end
    end
  end

  assign gnt_oh_c = gnt_vld_c ? (KEY_NUM'(1) << gnt_id_c) : '0;
  assign pop_c    = !fifo_empty_c && evt_ready;
  // A press is lost when its key is already pending and not drained this cycle.
  assign loss_c   = |(key_flag & pend_q & ~gnt_oh_c);

  // Next-state: pending bits, rr pointer, FIFO and sticky overflow.
  always_comb begin
    pend_d   = (pend_q & ~gnt_oh_c) | key_flag;
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    mem_d    = mem_q;

    if (gnt_vld_c) begin
      rr_d            = ID_W'((32'(gnt_id_c) + 32'd1) % KEY_NUM);
      mem_d[wr_ptr_q] = gnt_id_c;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(gnt_vld_c) - CNT_W'(pop_c);

    // Set beats clear.
    if (loss_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign evt_valid = !fifo_empty_c;
  assign evt_id    = fifo_empty_c ? '0 : mem_q[rd_ptr_q];
  assign pend      = pend_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_event_arb.sv
// Testbench for key_event_arb: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_key_event_arb;

  localparam int unsigned KEY_NUM    = 4;
  localparam int unsigned ID_W       = 2;
  localparam int unsigned FIFO_DEPTH = 4;

  logic               clk;
  logic               rst_n;
  logic [KEY_NUM-1:0] key_flag;
  logic               evt_valid;
  logic [ID_W-1:0]    evt_id;
  logic               evt_ready;
  logic [KEY_NUM-1:0] pend;
  logic               ovf;
  logic               ovf_clr;

  key_event_arb #(
    .KEY_NUM   (KEY_NUM),
    .ID_W      (ID_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_flag (key_flag),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_ready(evt_ready),
    .pend     (pend),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state.
  bit [KEY_NUM-1:0] m_pend;
  int               m_rr;
  int               m_q[$];
  bit               m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_rr   = 0;
    m_q.delete();
    m_ovf  = 1'b0;
  endtask

  // One rising edge of the reference model.
  task automatic model_step(input bit [KEY_NUM-1:0] kf, input bit rdy, input bit clr);
    int  gnt;
    bit  pop;
    bit  loss;
    gnt = -1;
    if (m_pend != 0 && m_q.size() < FIFO_DEPTH) begin
      for (int i = 0; i < KEY_NUM; i++) begin
        int k;
        k = (m_rr + i) % KEY_NUM;
        if (gnt < 0 && m_pend[k]) gnt = k;
      end
    end
    pop  = (m_q.size() != 0) && rdy;
    loss = 1'b0;
    for (int k = 0; k < KEY_NUM; k++) begin
      if (kf[k] && m_pend[k] && gnt != k) loss = 1'b1;
    end
    for (int k = 0; k < KEY_NUM; k++) begin
      if (gnt == k) m_pend[k] = 1'b0;
      if (kf[k]) m_pend[k] = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (gnt >= 0) begin
      m_q.push_back(gnt);
      m_rr = (gnt + 1) % KEY_NUM;
    end
    if (loss) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
    chk({tag, ".id"},    32'(evt_id),    (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk({tag, ".pend"},  32'(pend),      32'(m_pend));
    chk({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
  endtask

  // Called at a falling edge: drive, clock, model, check at next falling edge.
  task automatic cycle(input bit [KEY_NUM-1:0] kf, input bit rdy, input bit clr, input string tag);
    key_flag  = kf;
    evt_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    model_step(kf, rdy, clr);
    @(negedge clk);
    check_outputs(tag);
  endtask

  // One-cycle asynchronous reset pulse, asserted mid-cycle.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, ".rst_pend"},  32'(pend),      32'd0);
    chk({tag, ".rst_id"},    32'(evt_id),    32'd0);
    chk({tag, ".rst_ovf"},   32'(ovf),       32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    key_flag  = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();

    // Reset held: outputs stay zero regardless of key activity.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      key_flag  = KEY_NUM'($urandom);
      evt_ready = 1'(i);
      @(posedge clk);
      @(negedge clk);
      chk("hold_rst.valid", 32'(evt_valid), 32'd0);
      chk("hold_rst.id",    32'(evt_id),    32'd0);
      chk("hold_rst.pend",  32'(pend),      32'd0);
      chk("hold_rst.ovf",   32'(ovf),       32'd0);
    end
    rst_n = 1'b1;

    // Single press of key 2.
    cycle(4'b0100, 1'b1, 1'b0, "single0");
    chk("single.pend", 32'(pend), 32'h4);
    cycle(4'b0000, 1'b1, 1'b0, "single1");
    chk("single.id", 32'(evt_id), 32'd2);
    cycle(4'b0000, 1'b1, 1'b0, "single2");
    chk("single.empty", 32'(evt_valid), 32'd0);

    // Simultaneous presses from rr=0 after reset.
    pulse_reset("rr0");
    cycle(4'b1111, 1'b1, 1'b0, "sim_a");
    for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1, 1'b0, "sim_a_drain");
    cycle(4'b1111, 1'b1, 1'b0, "sim_b");
    for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1, 1'b0, "sim_b_drain");
    // Move rr to 2 by granting key 1 alone.
    cycle(4'b0010, 1'b1, 1'b0, "rr2_set");
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b0, "rr2_drain");
    cycle(4'b1111, 1'b1, 1'b0, "sim_c");
    cycle(4'b0000, 1'b1, 1'b0, "sim_c1");
    chk("sim_c.first_id", 32'(evt_id), 32'd2);
    for (int i = 0; i < 5; i++) cycle(4'b0000, 1'b1, 1'b0, "sim_c_drain");

    // Full FIFO, one held press, then a lost press.
    cycle(4'b0001, 1'b0, 1'b0, "full0");
    cycle(4'b0010, 1'b0, 1'b0, "full1");
    cycle(4'b0100, 1'b0, 1'b0, "full2");
    cycle(4'b1000, 1'b0, 1'b0, "full3");
    cycle(4'b0001, 1'b0, 1'b0, "full4");
    chk("full.pend", 32'(pend), 32'h1);
    cycle(4'b0001, 1'b0, 1'b0, "full5");
    chk("full.ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 7; i++) cycle(4'b0000, 1'b1, 1'b0, "full_drain");

    // ovf clear without and with a coincident loss.
    cycle(4'b0000, 1'b1, 1'b1, "clr_plain");
    chk("clr_plain.ovf", 32'(ovf), 32'd0);
    cycle(4'b0001, 1'b0, 1'b0, "race0");
    cycle(4'b0010, 1'b0, 1'b0, "race1");
    cycle(4'b0100, 1'b0, 1'b0, "race2");
    cycle(4'b1000, 1'b0, 1'b0, "race3");
    cycle(4'b0001, 1'b0, 1'b0, "race4");
    cycle(4'b0001, 1'b0, 1'b1, "race5");
    chk("race.ovf", 32'(ovf), 32'd1);
    cycle(4'b0000, 1'b1, 1'b1, "race_clr");
    for (int i = 0; i < 7; i++) cycle(4'b0000, 1'b1, 1'b0, "race_drain");

    // Reset mid-operation with three events queued and key 1 pending.
    cycle(4'b0001, 1'b0, 1'b0, "mid0");
    cycle(4'b0010, 1'b0, 1'b0, "mid1");
    cycle(4'b0100, 1'b0, 1'b0, "mid2");
    cycle(4'b0010, 1'b0, 1'b0, "mid3");
    chk("mid.pend", 32'(pend), 32'h2);
    pulse_reset("mid");
    cycle(4'b1000, 1'b1, 1'b0, "mid_k3");
    cycle(4'b0000, 1'b1, 1'b0, "mid_k3_out");
    chk("mid.k3_id", 32'(evt_id), 32'd3);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b0, "mid_tail");

    // Randomized traffic with occasional backpressure, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      bit [KEY_NUM-1:0] kf;
      bit rdy;
      bit clr;
      if ($urandom_range(0, 299) == 0) pulse_reset("rnd");
      kf  = KEY_NUM'($urandom & $urandom);
      rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      cycle(kf, rdy, clr, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
